// File: rtl/shared_reg_arbiter.sv
// Four-requester round-robin arbiter guarding one shared storage register.
// Define SHARED_REG_ARB_TIMEOUT_EN to revoke grants after MAX_HOLD cycles.
module shared_reg_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         wr,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   rdata,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg;
  logic [3:0]       gnt_reg;
  logic [1:0]       last_reg;
  logic [WIDTH-1:0] data_reg;
  logic             timeout_reg;

  logic [WIDTH-1:0] slice [4];
  logic             found_next;
  logic [1:0]       winner_next;
  logic             expire;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotating search starting just after the previous winner.
  always_comb begin
    logic [1:0] idx;
    found_next  = 1'b0;
    winner_next = last_reg;
    idx         = last_reg;
    for (int i = 1; i <= 4; i++) begin
      idx = last_reg + 2'(i);
      if (!found_next && req[idx]) begin
        found_next  = 1'b1;
        winner_next = idx;
      end
    end
  end

`ifdef SHARED_REG_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  // hold_reg holds the 1-based index of the current grant cycle.
  logic [HW-1:0] hold_reg;

  assign expire = (state_reg == GRANT) && (hold_reg == HW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (state_reg == IDLE && found_next) begin
      hold_reg <= HW'(1);
    end else if (state_reg == GRANT && req[last_reg] && !expire) begin
      hold_reg <= hold_reg + HW'(1);
    end else begin
      hold_reg <= '0;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= 4'b0000;
      last_reg    <= 2'd3;
      data_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found_next) begin
            state_reg <= GRANT;
            gnt_reg   <= 4'b0001 << winner_next;
            last_reg  <= winner_next;
          end
        end
        GRANT: begin
          if (req[last_reg]) begin
            // A write in the final allowed cycle still lands before revocation.
            if (wr[last_reg]) data_reg <= slice[last_reg];
            if (expire) begin
              state_reg   <= IDLE;
              gnt_reg     <= 4'b0000;
              timeout_reg <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign rdata   = data_reg;
  assign busy    = (state_reg == GRANT);
  assign timeout = timeout_reg;

endmodule
